// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the divide-by-zero quotient.
package mdu_pkg;

   localparam logic [1:0] MDU_DIV   = 2'b00;
   localparam logic [1:0] MDU_DIVU  = 2'b01;
   localparam logic [1:0] MDU_MULT  = 2'b10;
   localparam logic [1:0] MDU_MULTU = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } mdu_state_t;

   // Wide enough for any WIDTH up to 64; users slice the low WIDTH bits.
   localparam logic [63:0] MDU_DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU bus. The pipeline drives the master side, mdu_ctrl the slave.
interface mdu_ctrl_if #(
   parameter int WIDTH = 32
);
   // start is a level held by EX while stall is high; the op is taken in the
   // IDLE cycle with start=1 and flush=0, and done pulses once when hi/lo update.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input stall, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output stall, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// One combinational MDU step: restoring divide (shift, trial subtract), and
// with MDU_MULT_ITER_EN defined also a shift-add multiply step.
module mdu_iter #(
   parameter int WIDTH = 32
) (
`ifdef MDU_MULT_ITER_EN
   input  logic             is_mult,
`endif
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;
`ifdef MDU_MULT_ITER_EN
   logic [WIDTH:0]   sum;
`endif

   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, dvs_i});
      // When ge holds the true difference is below 2^WIDTH, so the low bits suffice.
      diff   = rem_sh[WIDTH-1:0] - dvs_i;
      if (ge) begin
         rem_o = diff;
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
`ifdef MDU_MULT_ITER_EN
      // Accumulator in rem, multiplier shifting out of quo; carry folds into the shift.
      sum = {1'b0, rem_i} + (quo_i[0] ? {1'b0, dvs_i} : '0);
      if (is_mult) begin
         rem_o = sum[WIDTH:1];
         quo_o = {sum[0], quo_i[WIDTH-1:1]};
      end
`endif
   end
endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: FSM, step counter, magnitude/sign handling and HI/LO registers.
// Define MDU_MULT_ITER_EN for WIDTH-cycle shift-add multiplies instead of a '*'.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   mdu_ctrl_if.slave  bus,
   output mdu_state_t dbg_state
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mdu_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;
   logic [WIDTH-1:0] rem_nx, quo_nx, a_mag, b_mag;
   logic             sgn, a_neg, b_neg, accept;
`ifdef MDU_MULT_ITER_EN
   logic             is_mult_q, is_mult_d;
   logic [2*WIDTH-1:0] prod_mag;
`else
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
`endif

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
`ifdef MDU_MULT_ITER_EN
      .is_mult (is_mult_q),
`endif
      .rem_i   (rem_q),
      .quo_i   (quo_q),
      .dvs_i   (dvs_q),
      .rem_o   (rem_nx),
      .quo_o   (quo_nx)
   );

   assign accept    = (state_q == S_IDLE) & bus.start & ~bus.flush;
   assign bus.stall = accept | (state_q == S_RUN);
   assign bus.done  = (state_q == S_DONE);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign dbg_state = state_q;

   always_comb begin
      sgn   = ~bus.op[0];
      a_neg = sgn & bus.a[WIDTH-1];
      b_neg = sgn & bus.b[WIDTH-1];
      a_mag = a_neg ? -bus.a : bus.a;
      b_mag = b_neg ? -bus.b : bus.b;
`ifndef MDU_MULT_ITER_EN
      // Sign-extending only for MULT makes one unsigned multiply serve both ops.
      a_ext = {{WIDTH{a_neg}}, bus.a};
      b_ext = {{WIDTH{b_neg}}, bus.b};
      prod  = a_ext * b_ext;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      div0_d  = div0_q;
`ifdef MDU_MULT_ITER_EN
      is_mult_d = is_mult_q;
      prod_mag  = {rem_nx, quo_nx};
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = a_mag;
               dvs_d   = b_mag;
               q_neg_d = a_neg ^ b_neg;
               r_neg_d = a_neg;
               div0_d  = ~bus.op[1] & (bus.b == '0);
               state_d = S_RUN;
`ifdef MDU_MULT_ITER_EN
               is_mult_d = bus.op[1];
`else
               if (bus.op[1]) begin
                  {hi_d, lo_d} = prod;
                  state_d      = S_DONE;
               end
`endif
            end
         end
         S_RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
               lo_d    = div0_q ? MDU_DIV0_QUOT[WIDTH-1:0] : (q_neg_q ? -quo_nx : quo_nx);
               hi_d    = r_neg_q ? -rem_nx : rem_nx;
`ifdef MDU_MULT_ITER_EN
               if (is_mult_q) {hi_d, lo_d} = q_neg_q ? -prod_mag : prod_mag;
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A flush abandons everything, including a result about to be written.
      if (bus.flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         div0_q  <= 1'b0;
`ifdef MDU_MULT_ITER_EN
         is_mult_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         div0_q  <= div0_d;
`ifdef MDU_MULT_ITER_EN
         is_mult_q <= is_mult_d;
`endif
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: cycle-level reference model (latency countdown plus
// arithmetic results) checked every cycle, and directed literal cases.
module tb_mdu_ctrl;
   import mdu_pkg::*;

`ifdef MDU_MULT_ITER_EN
   localparam int MLAT = 33;
`else
   localparam int MLAT = 1;
`endif
   localparam int DLAT = 33;

   logic       clk;
   logic       rst;
   mdu_state_t dbg_state;
   int         n_checks = 0;
   int         n_fail   = 0;

   mdu_ctrl_if #(.WIDTH(32)) bus ();

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
      longint sx, sy, q, r;
      if (!o[1]) begin
         if (y == 32'd0) return {x, 32'hFFFF_FFFF};
         if (o == MDU_DIV) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
         end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
         end
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
      if (o == MDU_MULT) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         q  = sx * sy;
         return q;
      end
      return {32'd0, x} * {32'd0, y};
   endfunction

   // ---------------- scoreboard / per-cycle compare ----------------
   logic [63:0] exp_q[$];
   logic [63:0] m_hilo  = '0;
   bit          pend    = 1'b0;
   longint      due     = 0;
   longint      cyc     = 0;

   always @(negedge clk) begin
      bit in_done, running, idle, take;
      if (rst) begin
         pend   = 1'b0;
         m_hilo = '0;
         exp_q.delete();
         chk("rst_done", {63'd0, bus.done}, 64'd0);
         chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
         chk("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      end else begin
         in_done = pend && (cyc == due);
         running = pend && (cyc < due);
         idle    = !pend;
         take    = idle && bus.start && !bus.flush;
         if (in_done && exp_q.size() > 0) m_hilo = exp_q.pop_front();
         chk("stall", {63'd0, bus.stall}, {63'd0, running | take});
         chk("done", {63'd0, bus.done}, {63'd0, in_done});
         chk("hilo", {bus.hi, bus.lo}, m_hilo);
         chk("state", {62'd0, dbg_state},
             {62'd0, in_done ? S_DONE : (running ? S_RUN : S_IDLE)});
         if (in_done) pend = 1'b0;
         if (running && bus.flush) begin
            pend = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
         end
         if (take) begin
            exp_q.push_back(ref_result(bus.op, bus.a, bus.b));
            pend = 1'b1;
            due  = cyc + longint'(bus.op[1] ? MLAT : DLAT);
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
   endtask

   task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp_hilo, input int exp_lat);
      int lat;
      lat = 0;
      issue(o, x, y);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({name, "_hilo"}, {bus.hi, bus.lo}, exp_hilo);
   endtask

   task automatic expect_no_done(input string name, input logic [63:0] exp_hilo);
      int seen;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk({name, "_nodone"}, 64'(seen), 64'd0);
      chk({name, "_hold"}, {bus.hi, bus.lo}, exp_hilo);
   endtask

   function automatic logic [31:0] rand_a();
      case ($urandom_range(0, 9))
         0:       return 32'h8000_0000;
         1, 2:    return $urandom_range(0, 200);
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_b();
      case ($urandom_range(0, 9))
         0:       return 32'd0;
         1, 2:    return $urandom_range(1, 15);
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = MDU_DIVU; bus.a = '0; bus.b = '0;

      chk("model_divu", ref_result(MDU_DIVU, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
      chk("model_div", ref_result(MDU_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_ovf", ref_result(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
      chk("model_mult", ref_result(MDU_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
      chk("model_multu", ref_result(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);

      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("init_stall", {63'd0, bus.stall}, 64'd0);
      chk("init_done", {63'd0, bus.done}, 64'd0);
      chk("init_hilo", {bus.hi, bus.lo}, 64'd0);

      run_lit("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DLAT);
      run_lit("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DLAT);
      run_lit("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DLAT);
      run_lit("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, DLAT);
      run_lit("div_by0", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, DLAT);
      run_lit("mult_m3_5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, MLAT);
      run_lit("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MLAT);

      // Flush a DIVU in cycle T+10.
      issue(MDU_DIVU, 32'd5000, 32'd3);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_stall", {63'd0, bus.stall}, 64'd0);
      expect_no_done("flush", 64'hFFFF_FFFE_0000_0001);

      // start and flush together in IDLE: not accepted.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd77; bus.b = 32'd7;
      @(negedge clk);
      chk("sf_stall", {63'd0, bus.stall}, 64'd0);
      @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
      expect_no_done("start_flush", 64'hFFFF_FFFE_0000_0001);

      // Asynchronous reset in the middle of a divide.
      issue(MDU_DIVU, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("amid_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("amid_done", {63'd0, bus.done}, 64'd0);
      chk("amid_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      run_lit("divu_9_3", MDU_DIVU, 32'd9, 32'd3, 64'h0000_0000_0000_0003, DLAT);

      // Random traffic; the per-cycle model checks every output.
      repeat (3000) begin
         @(posedge clk); #1;
         bus.start = ($urandom_range(0, 99) < 30);
         bus.flush = ($urandom_range(0, 99) < 1);
         bus.op    = 2'($urandom_range(0, 3));
         bus.a     = rand_a();
         bus.b     = rand_b();
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
